// File: rtl/mouse_pkg.sv
// Shared constants, packet FSM state type and the cursor clamp helper for the
// PS/2 mouse register block.
package mouse_pkg;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned REG_W  = 8;
   localparam int unsigned ACC_W  = 10;

   localparam logic [ADDR_W-1:0] REG_STATUS = 2'd0;
   localparam logic [ADDR_W-1:0] REG_X      = 2'd1;
   localparam logic [ADDR_W-1:0] REG_Y      = 2'd2;
   localparam logic [ADDR_W-1:0] REG_ERR    = 2'd3;

   localparam int unsigned BTN_L   = 0;
   localparam int unsigned BTN_R   = 1;
   localparam int unsigned BTN_M   = 2;
   localparam int unsigned ALWAYS1 = 3;
   localparam int unsigned XS      = 4;
   localparam int unsigned YS      = 5;
   localparam int unsigned XOV     = 6;
   localparam int unsigned YOV     = 7;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } pkt_state_t;

   // Clamp a signed candidate position into [0, vmax].
   function automatic logic [REG_W-1:0] clamp_loc(input logic signed [ACC_W-1:0] v,
                                                   input logic [REG_W-1:0] vmax);
      logic signed [ACC_W-1:0] hi;
      hi = $signed({2'b00, vmax});
      if (v < 10'sd0) return 8'd0;
      if (v > hi)     return vmax;
      return v[REG_W-1:0];
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: synchronisers, falling-edge detect,
// 11-bit frame shifter, odd-parity/stop check. Extra abort/busy/edge ports exist
// only when PS2_MOUSE_TIMEOUT_EN is defined.
module ps2_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
`ifdef PS2_MOUSE_TIMEOUT_EN
   input  logic       abort,
   output logic       busy,
   output logic       ps2_fall_c,
`endif
   output logic [7:0] rx_byte,
   output logic       byte_ok,
   output logic       byte_err
);

   localparam int unsigned CNT_W = 4;

   logic             clk_s1, clk_s2, clk_prev;
   logic             dat_s1, dat_s2;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       shreg;
   logic             par;
   logic             fall_c;
   logic             abort_c;

`ifdef PS2_MOUSE_TIMEOUT_EN
   assign abort_c    = abort;
   assign ps2_fall_c = fall_c;
`else
   logic busy;
   assign abort_c = 1'b0;
`endif

   assign fall_c = clk_prev & ~clk_s2;

   // Synchronisers idle high so reset release never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         busy     <= 1'b0;
         cnt      <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         rx_byte  <= '0;
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;
         if (abort_c) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else if (fall_c) begin
            if (!busy) begin
               if (!dat_s2) begin
                  busy <= 1'b1;
                  cnt  <= CNT_W'(1);
               end
            end else if (cnt <= CNT_W'(8)) begin
               shreg <= {dat_s2, shreg[7:1]};
               cnt   <= cnt + CNT_W'(1);
            end else if (cnt == CNT_W'(9)) begin
               par <= dat_s2;
               cnt <= CNT_W'(10);
            end else begin
               busy    <= 1'b0;
               cnt     <= '0;
               rx_byte <= shreg;
               if ((^{shreg, par}) && dat_s2) byte_ok  <= 1'b1;
               else                           byte_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_mouse_regs.sv
// PS/2 mouse packet decoder with clamped absolute cursor registers and a
// combinational read port. PS2_MOUSE_TIMEOUT_EN adds an inactivity resync.
import mouse_pkg::*;

module ps2_mouse_regs #(
   parameter logic [7:0] X_MAX = 8'd255,
   parameter logic [7:0] Y_MAX = 8'd255
`ifdef PS2_MOUSE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   input  logic [ADDR_W-1:0] addr,
   output logic [REG_W-1:0]  data,
   output logic              packet_stb
);

   logic [REG_W-1:0] rx_byte;
   logic             byte_ok, byte_err;
   logic             timeout_c;

   pkt_state_t       state, state_nxt;
   logic             lat0_c, lat1_c, apply_c;
   logic [REG_W-1:0] b0, b1;
   logic [REG_W-1:0] status, x_loc, y_loc, err_cnt;
   logic signed [ACC_W-1:0] dx_c, dy_c, nx_c, ny_c;
   logic [REG_W-1:0] new_x_c, new_y_c;

`ifdef PS2_MOUSE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic            rx_busy;
   logic            ps2_fall_c;
   logic [TO_W-1:0] idle_cnt;

   ps2_rx u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .abort      (timeout_c),
      .busy       (rx_busy),
      .ps2_fall_c (ps2_fall_c),
      .rx_byte    (rx_byte),
      .byte_ok    (byte_ok),
      .byte_err   (byte_err)
   );

   // Inactivity counter, cleared by every PS/2 clock falling edge.
   always_ff @(posedge clk) begin
      if (!rst)                                     idle_cnt <= '0;
      else if (ps2_fall_c)                          idle_cnt <= '0;
      else if (idle_cnt != TO_W'(TIMEOUT_CYCLES))   idle_cnt <= idle_cnt + TO_W'(1);
   end

   assign timeout_c = (idle_cnt == TO_W'(TIMEOUT_CYCLES)) && (rx_busy || (state != WAIT_B0));
`else
   ps2_rx u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_ok  (byte_ok),
      .byte_err (byte_err)
   );

   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= WAIT_B0;
      else      state <= state_nxt;
   end

   // Packet assembly; bytes without the always-one bit are dropped to realign.
   always_comb begin
      state_nxt = state;
      lat0_c    = 1'b0;
      lat1_c    = 1'b0;
      apply_c   = 1'b0;
      if (byte_err) begin
         state_nxt = WAIT_B0;
      end else if (byte_ok) begin
         case (state)
            WAIT_B0: if (rx_byte[ALWAYS1]) begin
               lat0_c    = 1'b1;
               state_nxt = WAIT_B1;
            end
            WAIT_B1: begin
               lat1_c    = 1'b1;
               state_nxt = WAIT_B2;
            end
            WAIT_B2: begin
               apply_c   = 1'b1;
               state_nxt = WAIT_B0;
            end
            default: state_nxt = WAIT_B0;
         endcase
      end
      if (timeout_c) state_nxt = WAIT_B0;
   end

   // Screen y grows downward while PS/2 dy is positive upward.
   always_comb begin
      dx_c    = {b0[XS], b0[XS], b1};
      dy_c    = {b0[YS], b0[YS], rx_byte};
      nx_c    = $signed({2'b00, x_loc}) + dx_c;
      ny_c    = $signed({2'b00, y_loc}) - dy_c;
      new_x_c = clamp_loc(nx_c, X_MAX);
      new_y_c = clamp_loc(ny_c, Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         b0         <= '0;
         b1         <= '0;
         status     <= '0;
         x_loc      <= '0;
         y_loc      <= '0;
         err_cnt    <= '0;
         packet_stb <= 1'b0;
      end else begin
         packet_stb <= apply_c;
         if (lat0_c) b0 <= rx_byte;
         if (lat1_c) b1 <= rx_byte;
         if (apply_c) begin
            status <= b0;
            if (!b0[XOV]) x_loc <= new_x_c;
            if (!b0[YOV]) y_loc <= new_y_c;
         end
         if (byte_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + REG_W'(1);
      end
   end

   always_comb begin
      data = '0;
      case (addr)
         REG_STATUS: data = status;
         REG_X:      data = x_loc;
         REG_Y:      data = y_loc;
         REG_ERR:    data = err_cnt;
         default:    data = '0;
      endcase
   end

endmodule

// File: doc/ps2_mouse_regs.md
Name: ps2_mouse_regs

Overview:
- Responder side of the mouse register read port (addr/data) used by the mouse display logic.
- Receives raw PS/2 device-to-host frames from the mouse and assembles standard 3-byte movement packets.
- Accumulates an absolute, clamped cursor position from those packets.
- Serves status, x_loc and y_loc to any reader through a combinational 2-bit address / 8-bit data port.

Parameters:
- X_MAX, 8'd255, largest legal x_loc value (inclusive).
- Y_MAX, 8'd255, largest legal y_loc value (inclusive).
- TIMEOUT_CYCLES, 50000, clk cycles of PS/2 inactivity before resync (used only with the optional feature).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock from the mouse; asynchronous.
- ps2_data  input  1  raw PS/2 data from the mouse; asynchronous.
- addr  input  2  register select: 0 = status, 1 = x_loc, 2 = y_loc, 3 = error count.
- data  output  8  selected register value; combinational from addr.
- packet_stb  output  1  one-cycle pulse when a complete packet is applied.

Behaviour:
- Reset (rst low at a clk edge):
  - status, x_loc, y_loc, err_cnt and packet_stb go to 0; receiver and packet FSM return to idle.
  - data therefore reads 0 at every address.
  - Reset mid-frame discards any partial byte or packet.
- Synchronisation: ps2_clk and ps2_data each pass through two flops. A falling edge is detected on the synchronised ps2_clk (previous = 1, current = 0), and ps2_data is sampled on that edge.
- Receiver:
  - Frame is 11 bits: start 0, D0..D7 LSB first, odd parity, stop 1. A 4-bit counter runs 0..10.
  - A start bit sampled as 1 is ignored; the receiver stays idle.
  - After the stop bit, byte_ok pulses for one cycle if parity is odd and stop = 1.
  - Otherwise byte_err pulses for one cycle, and err_cnt increments, saturating at 255.
- Packet FSM, states WAIT_B0, WAIT_B1, WAIT_B2:
  - WAIT_B0: on byte_ok with bit3 = 1, latch b0 and go to WAIT_B1. Bit3 = 0 drops the byte and stays (framing realignment).
  - WAIT_B1: on byte_ok, latch b1 and go to WAIT_B2.
  - WAIT_B2: on byte_ok, apply the packet and return to WAIT_B0.
  - Any byte_err, in any state, returns the FSM to WAIT_B0 and leaves the registers unchanged.
- Apply (the clk edge after the third byte_ok):
  - status <= b0.
  - dx = 9-bit signed {b0[4], b1}; dy = 9-bit signed {b0[5], b2}. Sign-extend to 10 bits.
  - nx = x_loc + dx; ny = y_loc - dy (PS/2 y is positive upward, screen y downward).
  - Clamp nx and ny to [0, X_MAX] and [0, Y_MAX].
  - If b0[6] (x overflow) is set, x_loc is unchanged. If b0[7] (y overflow) is set, y_loc is unchanged.
  - packet_stb = 1 for that one cycle.
- Read port:
  - data = status, x_loc, y_loc or err_cnt per addr, with zero latency.
  - A read in the same cycle as an apply returns the old value; the new value is visible from the next cycle.
- Host-to-device transmission is out of scope; ps2_clk and ps2_data are inputs only.

Optional Feature:
- Macro PS2_MOUSE_TIMEOUT_EN.
- Defined:
  - A counter clears on every synchronised ps2_clk falling edge and otherwise counts up, saturating.
  - When it reaches TIMEOUT_CYCLES while the receiver is mid-frame or the FSM is not in WAIT_B0, both return to idle / WAIT_B0.
  - Registers are unchanged and err_cnt does not increment.
- Undefined:
  - No counter is present.
  - Realignment happens only through byte_err and the b0 bit3 check.

Decomposition:
- Package mouse_pkg holds:
  - register address constants (REG_STATUS = 0, REG_X = 1, REG_Y = 2, REG_ERR = 3);
  - b0 bit indices (BTN_L = 0, BTN_R = 1, BTN_M = 2, ALWAYS1 = 3, XS = 4, YS = 5, XOV = 6, YOV = 7);
  - the packet FSM state enum.
- One sub-module, ps2_rx: synchronisers, edge detect, 11-bit shifter and parity check. Outputs byte[7:0], byte_ok, byte_err, busy.
- ps2_mouse_regs holds the FSM, accumulator, clamp, err_cnt and the read mux.

Test Plan:
- Reset → addr 0/1/2/3 each read 8'h00; packet_stb stays 0.
- Bytes 08,14,00 → packet_stb pulses once; status = 08, x_loc = 20, y_loc = 0. Then 28,00,F6 → y_loc = 10 (0 - (-10)), x_loc stays 20.
- From x = 20, send 18,9C (dx = -100),00 → x_loc = 0 (clamped). Then 08,FF,00 twice → x_loc = 255. Then 48,05,00 (XOV set) → x_loc unchanged, status = 48.
- Byte1 sent with bad parity → no packet_stb, registers unchanged, err_cnt = 1. The following valid packet 09,01,00 is applied: status = 09, x_loc += 1.
- Byte 01 (bit3 = 0) then packet 08,02,00 → first byte dropped; packet applied, x_loc += 2.
- PS2_MOUSE_TIMEOUT_EN defined: send 08,05, idle TIMEOUT_CYCLES + 10, then 08,03,00 → only x_loc += 3 applied. With the macro undefined, the same stimulus applies 08,05,08 instead → x_loc += 5, y_loc -= 8 (clamped).
